// File: rtl/multicycle_control_pkg.sv
// multicycle_control_pkg: opcodes, FSM states, datapath select codes and the per-state control word.
// MC_IMM_ALU_EN adds the IEXEC/IWB states for addi/andi/ori.
package multicycle_control_pkg;
  localparam int OPW = 6;
  localparam int ST_W = 4;
  localparam logic [OPW-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPW-1:0] OP_LW    = 6'h23;
  localparam logic [OPW-1:0] OP_SW    = 6'h2B;
  localparam logic [OPW-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPW-1:0] OP_BNE   = 6'h05;
  localparam logic [OPW-1:0] OP_J     = 6'h02;
  localparam logic [OPW-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPW-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OPW-1:0] OP_ORI   = 6'h0D;
  localparam logic [1:0] ALU_ADD = 2'd0, ALU_SUB = 2'd1, ALU_FUNCT = 2'd2, ALU_IMM = 2'd3;
  localparam logic [1:0] SRCB_REG = 2'd0, SRCB_FOUR = 2'd1, SRCB_IMM = 2'd2, SRCB_IMM_SH = 2'd3;
  localparam logic [1:0] PCS_ALU = 2'd0, PCS_ALUOUT = 2'd1, PCS_JUMP = 2'd2;
  typedef enum logic [ST_W-1:0] {
    IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, JUMP
`ifdef MC_IMM_ALU_EN
    , IEXEC, IWB
`endif
  } state_t;
  typedef struct packed {
    logic       mem_req;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       fetch;
    logic       pc_write;
    logic       pc_write_if_zero;
    logic       pc_write_if_nonzero;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
  } ctrl_t;
  // Moore control word for a state; op selects beq/bne and addi/logic-imm variants.
  function automatic ctrl_t ctrl_of(state_t s, logic [OPW-1:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin c.mem_req = 1'b1; c.mem_read = 1'b1; c.fetch = 1'b1; c.alu_src_b = SRCB_FOUR; end
      DECODE: c.alu_src_b = SRCB_IMM_SH;
      MEMADR: begin c.alu_src_a = 1'b1; c.alu_src_b = SRCB_IMM; end
      MEMRD: begin c.mem_req = 1'b1; c.mem_read = 1'b1; c.i_or_d = 1'b1; end
      MEMWB: begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      MEMWR: begin c.mem_req = 1'b1; c.mem_write = 1'b1; c.i_or_d = 1'b1; end
      EXEC: begin c.alu_src_a = 1'b1; c.alu_op = ALU_FUNCT; end
      ALUWB: begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
      BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_op = ALU_SUB;
        c.pc_source = PCS_ALUOUT;
        c.pc_write_if_zero = op == OP_BEQ;
        c.pc_write_if_nonzero = op == OP_BNE;
      end
      JUMP: begin c.pc_write = 1'b1; c.pc_source = PCS_JUMP; end
`ifdef MC_IMM_ALU_EN
      IEXEC: begin c.alu_src_a = 1'b1; c.alu_src_b = SRCB_IMM; c.alu_op = op == OP_ADDI ? ALU_ADD : ALU_IMM; end
      IWB: c.reg_write = 1'b1;
`endif
      default: c = '0;
    endcase
    return c;
  endfunction
endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: opcode/memory handshake inputs and datapath control outputs of the control FSM.
interface multicycle_control_if;
  import multicycle_control_pkg::*;
  logic [OPW-1:0] opcode;
  logic mem_ready, mem_req, mem_read, mem_write, i_or_d, ir_write;
  logic pc_write, pc_write_if_zero, pc_write_if_nonzero;
  logic [1:0] pc_source, alu_op, alu_src_b;
  logic alu_src_a, reg_write, reg_dst, mem_to_reg, illegal_op;
  modport ctrl (
    input opcode, mem_ready,
    output mem_req, mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_if_zero,
      pc_write_if_nonzero, pc_source, alu_op, alu_src_a, alu_src_b, reg_write, reg_dst, mem_to_reg, illegal_op
  );
  modport dp (
    output opcode, mem_ready,
    input mem_req, mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_if_zero,
      pc_write_if_nonzero, pc_source, alu_op, alu_src_a, alu_src_b, reg_write, reg_dst, mem_to_reg, illegal_op
  );
endinterface

// File: rtl/multicycle_control_decode.sv
// multicycle_control_decode: opcode -> state following DECODE, plus illegal-opcode flag.
// MC_IMM_ALU_EN makes addi/andi/ori legal.
module multicycle_control_decode import multicycle_control_pkg::*; (
  input  logic [OPW-1:0] opcode,
  output state_t         next,
  output logic           illegal
);
  always_comb begin
    next = FETCH;
    illegal = 1'b0;
    case (opcode)
      OP_RTYPE: next = EXEC;
      OP_LW, OP_SW: next = MEMADR;
      OP_BEQ, OP_BNE: next = BRANCH;
      OP_J: next = JUMP;
`ifdef MC_IMM_ALU_EN
      OP_ADDI, OP_ANDI, OP_ORI: next = IEXEC;
`endif
      default: illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: main FSM of the multicycle CPU; control word is registered from the next state.
// MC_IMM_ALU_EN enables the immediate-ALU instruction path.
module multicycle_control import multicycle_control_pkg::*; (
  input logic clk,
  input logic rst_n,
  multicycle_control_if.ctrl bus
);
  state_t state, nxt, dec_next;
  logic dec_illegal, illegal;
  ctrl_t c;
  multicycle_control_decode u_dec (.opcode(bus.opcode), .next(dec_next), .illegal(dec_illegal));
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE: nxt = FETCH;
      FETCH: nxt = bus.mem_ready ? DECODE : FETCH;
      DECODE: nxt = dec_next;
      MEMADR: nxt = bus.opcode == OP_SW ? MEMWR : MEMRD;
      MEMRD: nxt = bus.mem_ready ? MEMWB : MEMRD;
      MEMWR: nxt = bus.mem_ready ? FETCH : MEMWR;
      EXEC: nxt = ALUWB;
`ifdef MC_IMM_ALU_EN
      IEXEC: nxt = IWB;
      IWB: nxt = FETCH;
`endif
      MEMWB, ALUWB, BRANCH, JUMP: nxt = FETCH;
      default: nxt = IDLE;
    endcase
  end
  // Registers clear asynchronously, so memReq and every control drop the moment rst_n falls.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      c <= '0;
      illegal <= 1'b0;
    end else begin
      state <= nxt;
      c <= ctrl_of(nxt, bus.opcode);
      illegal <= illegal | (state == DECODE && dec_illegal);
    end
  assign bus.mem_req = c.mem_req;
  assign bus.mem_read = c.mem_read;
  assign bus.mem_write = c.mem_write;
  assign bus.i_or_d = c.i_or_d;
  assign bus.ir_write = c.fetch & bus.mem_ready;
  assign bus.pc_write = c.pc_write | (c.fetch & bus.mem_ready);
  assign bus.pc_write_if_zero = c.pc_write_if_zero;
  assign bus.pc_write_if_nonzero = c.pc_write_if_nonzero;
  assign bus.pc_source = c.pc_source;
  assign bus.alu_op = c.alu_op;
  assign bus.alu_src_a = c.alu_src_a;
  assign bus.alu_src_b = c.alu_src_b;
  assign bus.reg_write = c.reg_write;
  assign bus.reg_dst = c.reg_dst;
  assign bus.mem_to_reg = c.mem_to_reg;
  assign bus.illegal_op = illegal;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: instruction-level step model vs DUT each cycle, directed checks plus random opcodes/waits.
module tb_multicycle_control;
  typedef enum {K_IDLE, K_FETCH, K_DEC, K_ADR, K_RD, K_RWB, K_WR, K_EX, K_AWB, K_BR, K_J, K_IEX, K_IWB} step_e;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  multicycle_control_if bus();
  multicycle_control dut (.clk(clk), .rst_n(rst_n), .bus(bus.ctrl));
  step_e cur = K_IDLE;
  step_e rest[$];
  logic ill = 1'b0;
  int total = 0, bad = 0;
  bit run = 0, rand_rdy = 0, rand_op = 0;
  logic [5:0] ops [11] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h08, 6'h0C, 6'h0D, 6'h3F, 6'h01};
  function automatic logic [18:0] dut_vec();
    return {bus.mem_req, bus.mem_read, bus.mem_write, bus.i_or_d, bus.ir_write, bus.pc_write,
            bus.pc_write_if_zero, bus.pc_write_if_nonzero, bus.pc_source, bus.alu_op, bus.alu_src_a,
            bus.alu_src_b, bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.illegal_op};
  endfunction
  // Control word per instruction step: {req,rd,wr,iord, irw,pcw, pcz,pcnz, pcsrc, aluop, srca, srcb, regw,regdst,m2r}
  function automatic logic [18:0] exp_vec(step_e s, logic [5:0] op, logic rdy, logic il);
    logic [17:0] v;
    case (s)
      K_FETCH: v = {4'b1100, rdy, rdy, 2'b00, 2'd0, 2'd0, 1'b0, 2'd1, 3'b000};
      K_DEC:   v = {4'b0000, 2'b00, 2'b00, 2'd0, 2'd0, 1'b0, 2'd3, 3'b000};
      K_ADR:   v = {4'b0000, 2'b00, 2'b00, 2'd0, 2'd0, 1'b1, 2'd2, 3'b000};
      K_RD:    v = {4'b1101, 2'b00, 2'b00, 2'd0, 2'd0, 1'b0, 2'd0, 3'b000};
      K_RWB:   v = {4'b0000, 2'b00, 2'b00, 2'd0, 2'd0, 1'b0, 2'd0, 3'b101};
      K_WR:    v = {4'b1011, 2'b00, 2'b00, 2'd0, 2'd0, 1'b0, 2'd0, 3'b000};
      K_EX:    v = {4'b0000, 2'b00, 2'b00, 2'd0, 2'd2, 1'b1, 2'd0, 3'b000};
      K_AWB:   v = {4'b0000, 2'b00, 2'b00, 2'd0, 2'd0, 1'b0, 2'd0, 3'b110};
      K_BR:    v = {4'b0000, 2'b00, op == 6'h04, op == 6'h05, 2'd1, 2'd1, 1'b1, 2'd0, 3'b000};
      K_J:     v = {4'b0000, 2'b01, 2'b00, 2'd2, 2'd0, 1'b0, 2'd0, 3'b000};
      K_IEX:   v = {4'b0000, 2'b00, 2'b00, 2'd0, op == 6'h08 ? 2'd0 : 2'd3, 1'b1, 2'd2, 3'b000};
      K_IWB:   v = {4'b0000, 2'b00, 2'b00, 2'd0, 2'd0, 1'b0, 2'd0, 3'b100};
      default: v = '0;
    endcase
    return {v, il};
  endfunction
  task automatic plan(input logic [5:0] op);
    case (op)
      6'h00: rest = {K_EX, K_AWB};
      6'h23: rest = {K_ADR, K_RD, K_RWB};
      6'h2B: rest = {K_ADR, K_WR};
      6'h04, 6'h05: rest = {K_BR};
      6'h02: rest = {K_J};
`ifdef MC_IMM_ALU_EN
      6'h08, 6'h0C, 6'h0D: rest = {K_IEX, K_IWB};
`endif
      default: rest = {};
    endcase
  endtask
  task automatic advance(input logic rdy);
    if (!rst_n) begin
      cur = K_IDLE; rest.delete(); ill = 1'b0;
    end else if (cur == K_IDLE) cur = K_FETCH;
    else if ((cur == K_FETCH || cur == K_RD || cur == K_WR) && !rdy) begin end
    else if (cur == K_FETCH) cur = K_DEC;
    else begin
      if (cur == K_DEC) begin plan(bus.opcode); ill = ill | (rest.size() == 0); end
      cur = rest.size() != 0 ? rest.pop_front() : K_FETCH;
    end
  endtask
  task automatic chk(input string name, input logic [18:0] got, input logic [18:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    cur = K_IDLE; rest.delete(); ill = 1'b0;
  endtask
  task automatic step_clk();
    @(posedge clk);
    advance(bus.mem_ready);
    #1;
    if (rand_rdy) bus.mem_ready = $urandom_range(0, 2) != 0;
    if (rand_op && cur == K_FETCH) bus.opcode = ops[$urandom_range(0, 10)];
    #1;
  endtask
  function automatic logic in_fetch();
    return bus.mem_read && !bus.i_or_d;
  endfunction
  // Starts in a fetch cycle; counts clocks until the next instruction's fetch.
  task automatic run_op(input string name, input logic [5:0] op, input int n_exp);
    int n = 0;
    bus.opcode = op;
    bus.mem_ready = 1'b1;
    #1;
    do begin
      step_clk();
      n++;
      if (op == 6'h04 && n == 2) chk("beq_terms", 19'({bus.pc_write_if_zero, bus.pc_write_if_nonzero, bus.pc_source}), 19'b1001);
      if (op == 6'h05 && n == 2) chk("bne_terms", 19'({bus.pc_write_if_zero, bus.pc_write_if_nonzero, bus.pc_source}), 19'b0101);
      if (op == 6'h23 && n == 4) chk("lw_wb", 19'({bus.reg_write, bus.mem_to_reg, bus.reg_dst}), 19'b110);
`ifdef MC_IMM_ALU_EN
      if (op == 6'h0D && n == 2) chk("ori_aluop", 19'(bus.alu_op), 19'd3);
      if (op == 6'h0D && n == 3) chk("ori_wb", 19'({bus.reg_write, bus.reg_dst}), 19'b10);
`endif
    end while (!in_fetch() && n < 20);
    chk(name, 19'(n), 19'(n_exp));
  endtask
  always @(negedge clk) if (run) chk("cycle", dut_vec(), exp_vec(cur, bus.opcode, bus.mem_ready, ill));
  initial begin
    int n;
    bus.opcode = 6'h23;
    bus.mem_ready = 1'b0;
    step_clk();
    run = 1;
    repeat (2) step_clk();
    chk("reset", dut_vec(), 19'd0);
    rst_n = 1'b1;
    step_clk();
    chk("fetch_entry", 19'({bus.mem_req, bus.mem_read}), 19'b11);
    repeat (2) begin
      step_clk();
      chk("fetch_wait", 19'({bus.ir_write, bus.pc_write, bus.mem_read}), 19'b001);
    end
    bus.mem_ready = 1'b1;
    #1;
    chk("fetch_ready", 19'({bus.ir_write, bus.pc_write}), 19'b11);
    step_clk();
    chk("decode", 19'({bus.mem_req, bus.alu_src_b}), 19'b011);
    n = 0;
    do begin step_clk(); n++; end while (!in_fetch() && n < 20);
    chk("lw_after_wait", 19'(n), 19'd4);
    run_op("cycles_r", 6'h00, 4);
    run_op("cycles_lw", 6'h23, 5);
    run_op("cycles_sw", 6'h2B, 4);
    run_op("cycles_beq", 6'h04, 3);
    run_op("cycles_bne", 6'h05, 3);
    run_op("cycles_j", 6'h02, 3);
    run_op("cycles_illegal", 6'h3F, 2);
    chk("illegal_set", 19'(bus.illegal_op), 19'd1);
    run_op("cycles_sw2", 6'h2B, 4);
    chk("illegal_sticky", 19'(bus.illegal_op), 19'd1);
    bus.opcode = 6'h2B;
    step_clk();
    bus.mem_ready = 1'b0;
    repeat (3) step_clk();
    chk("memwr_wait", 19'({bus.mem_req, bus.mem_write, bus.i_or_d}), 19'b111);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_reset", dut_vec(), 19'd0);
    repeat (2) step_clk();
    rst_n = 1'b1;
    bus.mem_ready = 1'b1;
    step_clk();
    chk("restart_fetch", 19'({bus.mem_req, bus.mem_read, bus.illegal_op}), 19'b110);
`ifdef MC_IMM_ALU_EN
    run_op("cycles_ori", 6'h0D, 4);
    chk("ori_legal", 19'(bus.illegal_op), 19'd0);
`else
    run_op("cycles_ori", 6'h0D, 2);
    chk("ori_illegal", 19'(bus.illegal_op), 19'd1);
`endif
    rand_rdy = 1;
    rand_op = 1;
    repeat (4000) begin
      step_clk();
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        model_reset();
        step_clk();
        rst_n = 1'b1;
      end
    end
    run = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
